// File: rtl/step_arbiter.sv
// rtl/step_arbiter.sv - round-robin job arbiter driving a shared mod-4 step counter
// Optional abort input is enabled by defining STEP_ARB_ABORT_EN.
module step_arbiter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_dir,
  input  logic [CNT_W-1:0] req0_steps,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dir,
  input  logic [CNT_W-1:0] req1_steps,
  output logic             req1_ready,
  output logic             step_en,
  output logic             step_dir,
  input  logic             wrap_in,
`ifdef STEP_ARB_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done_valid,
  output logic             done_id,
  output logic [CNT_W-1:0] done_wraps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state, state_nxt;
  logic             job_id;
  logic             job_dir;
  logic             last_grant;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] wraps;

  logic             any_req;
  logic             grant_id;
  logic             accept;
  logic             sel_dir;
  logic [CNT_W-1:0] sel_steps;
  logic             abort_hit;

`ifdef STEP_ARB_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign any_req   = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign accept    = (state == IDLE) & ~reset & any_req;
  assign sel_dir   = grant_id ? req1_dir   : req0_dir;
  assign sel_steps = grant_id ? req1_steps : req0_steps;

  // State register; reset discards any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; outputs come from registered state only
  // (plus abort), readies are the one combinational path from the requests.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    step_en    = 1'b0;
    step_dir   = 1'b0;
    busy       = 1'b0;
    done_valid = 1'b0;
    done_id    = 1'b0;
    done_wraps = ZERO;
    case (state)
      IDLE: begin
        req0_ready = accept & ~grant_id;
        req1_ready = accept &  grant_id;
        if (accept) begin
          state_nxt = (sel_steps != ZERO) ? RUN : DONE;
        end
      end
      RUN: begin
        busy     = 1'b1;
        step_en  = ~abort_hit;
        step_dir = job_dir;
        if (abort_hit || remaining == ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        done_id    = job_id;
        done_wraps = wraps;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Job datapath: latch on accept, count down steps and count wraps while
  // running, remember the owner for the next tie once the job completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_id     <= 1'b0;
      job_dir    <= 1'b0;
      remaining  <= ZERO;
      wraps      <= ZERO;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            job_id    <= grant_id;
            job_dir   <= sel_dir;
            remaining <= sel_steps;
            wraps     <= ZERO;
          end
        end
        RUN: begin
          if (!abort_hit) begin
            remaining <= remaining - ONE;
            if (wrap_in) begin
              wraps <= wraps + ONE;
            end
          end
        end
        DONE: begin
          last_grant <= job_id;
        end
        default: begin
          remaining <= ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_arbiter.sv
// tb/tb_step_arbiter.sv - directed self-checking bench for step_arbiter
module tb_step_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_dir, req0_ready;
  logic [3:0] req0_steps;
  logic       req1_valid, req1_dir, req1_ready;
  logic [3:0] req1_steps;
  logic       step_en, step_dir, wrap_in;
  logic       busy, done_valid, done_id;
  logic [3:0] done_wraps;
  logic       abort;
  logic       cnt_clear;
  logic [1:0] cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  step_arbiter #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_dir   (req0_dir),
    .req0_steps (req0_steps),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_dir   (req1_dir),
    .req1_steps (req1_steps),
    .req1_ready (req1_ready),
    .step_en    (step_en),
    .step_dir   (step_dir),
    .wrap_in    (wrap_in),
`ifdef STEP_ARB_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_wraps (done_wraps)
  );

  always #5 clk = ~clk;

  // Model of the shared counter: A=1 counts up and wraps when leaving S0,
  // A=0 counts down and wraps when leaving S3.
  always @(posedge clk) begin
    if (cnt_clear) cnt_s <= 2'd0;
    else if (step_en) cnt_s <= step_dir ? cnt_s + 2'd1 : cnt_s - 2'd1;
  end
  assign wrap_in = step_en & (step_dir ? (cnt_s == 2'd0) : (cnt_s == 2'd3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 4'd5;
    req1_valid = 1'b0; req1_dir = 1'b0; req1_steps = 4'd0;
    abort = 1'b0;
    cnt_clear = 1'b1;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_step_en", step_en, 0);
    chk("rst_step_dir", step_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_wraps", done_wraps, 0);

    // Job 1: req0, 5 steps up from S0.
    reset = 1'b0;
    #1;
    chk("j1_ready0", req0_ready, 1);
    chk("j1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; cnt_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("j1_step_en", step_en, 1);
      chk("j1_step_dir", step_dir, 1);
      chk("j1_busy", busy, 1);
      chk("j1_no_done", done_valid, 0);
      tick();
    end
    chk("j1_step_en_off", step_en, 0);
    chk("j1_done_valid", done_valid, 1);
    chk("j1_done_id", done_id, 0);
    chk("j1_done_wraps", done_wraps, 2);
    tick();
    chk("j1_idle_done", done_valid, 0);
    chk("j1_idle_busy", busy, 0);

    // Ties after reset: req0, then req1, then req0 again.
    reset = 1'b1; #1; reset = 1'b0;
    req0_valid = 1'b1; req0_dir = 1'b0; req0_steps = 4'd1;
    req1_valid = 1'b1; req1_dir = 1'b1; req1_steps = 4'd2;
    #1;
    chk("tie1_ready0", req0_ready, 1);
    chk("tie1_ready1", req1_ready, 0);
    tick();
    chk("tie1_run_ready0", req0_ready, 0);
    chk("tie1_run_ready1", req1_ready, 0);
    chk("tie1_step_en", step_en, 1);
    tick();
    chk("tie1_done_valid", done_valid, 1);
    chk("tie1_done_id", done_id, 0);
    chk("tie1_done_ready1", req1_ready, 0);
    tick();
    chk("tie2_ready1", req1_ready, 1);
    chk("tie2_ready0", req0_ready, 0);
    tick();
    chk("tie2_step_dir", step_dir, 1);
    tick();
    chk("tie2_step_en2", step_en, 1);
    tick();
    chk("tie2_done_valid", done_valid, 1);
    chk("tie2_done_id", done_id, 1);
    tick();
    chk("tie3_ready0", req0_ready, 1);
    chk("tie3_ready1", req1_ready, 0);

    // Zero-length job from req1.
    req0_valid = 1'b0; req1_steps = 4'd0;
    #1;
    chk("z_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("z_step_en", step_en, 0);
    chk("z_done_valid", done_valid, 1);
    chk("z_done_id", done_id, 1);
    chk("z_done_wraps", done_wraps, 0);
    tick();
    chk("z_idle_step_en", step_en, 0);
    chk("z_idle_done", done_valid, 0);

    // Job: req0, 15 steps down from S0.
    cnt_clear = 1'b1;
    req0_valid = 1'b1; req0_dir = 1'b0; req0_steps = 4'd15;
    #1;
    chk("j15_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0; cnt_clear = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("j15_step_en", step_en, 1);
      chk("j15_step_dir", step_dir, 0);
      tick();
    end
    chk("j15_done_valid", done_valid, 1);
    chk("j15_done_id", done_id, 0);
    chk("j15_done_wraps", done_wraps, 4);
    tick();

    // Reset in the third RUN cycle.
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 4'd8;
    #1;
    chk("rr_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    chk("rr_run3_step_en", step_en, 1);
    reset = 1'b1;
    #1;
    chk("rr_step_en", step_en, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rr_after_done", done_valid, 0);
    chk("rr_after_busy", busy, 0);
    cnt_clear = 1'b1;
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 4'd1;
    req1_valid = 1'b1; req1_dir = 1'b0; req1_steps = 4'd3;
    #1;
    chk("rr_tie_ready0", req0_ready, 1);
    chk("rr_tie_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; cnt_clear = 1'b0;
    chk("rr_step_en", step_en, 1);
    tick();
    chk("rr_done_valid", done_valid, 1);
    chk("rr_done_id", done_id, 0);
    chk("rr_done_wraps", done_wraps, 1);
    tick();

`ifdef STEP_ARB_ABORT_EN
    // Abort in the fourth RUN cycle of a 10-step job.
    cnt_clear = 1'b1;
    req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 4'd10;
    #1;
    chk("ab_ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0; cnt_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ab_step_en", step_en, 1);
      tick();
    end
    abort = 1'b1;
    #1;
    chk("ab_step_en_off", step_en, 0);
    tick();
    abort = 1'b0;
    chk("ab_done_valid", done_valid, 1);
    chk("ab_done_id", done_id, 0);
    chk("ab_done_wraps", done_wraps, 1);
    tick();
    chk("ab_idle_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/step_arbiter.md
# step_arbiter

Round-robin controller that shares one reversible mod-4 step counter (the Mealy up/down FSM with wrap output) between two requesters. Each requester submits a job (direction + step count) over a valid/ready handshake. The block drives the counter's step enable and direction, counts the wrap pulses the counter reports, and returns a one-cycle completion record. It sits between the job sources and the counter's clock-enable/direction inputs.

## Interface
- CNT_W, 4, width of step count and wrap count fields (job length 0..2^CNT_W-1)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- req0_valid  in  1  requester 0 job offered
- req0_dir  in  1  requester 0 direction (1 = A high, 0 = A low)
- req0_steps  in  CNT_W  requester 0 step count
- req0_ready  out  1  requester 0 job accepted this cycle
- req1_valid / req1_dir / req1_steps / req1_ready  same as requester 0
- step_en  out  1  counter advances this cycle
- step_dir  out  1  value driven onto counter input A
- wrap_in  in  1  counter Mealy output, valid in the same cycle as step_en
- busy  out  1  job in progress (state != IDLE)
- done_valid  out  1  one-cycle completion pulse
- done_id  out  1  requester that owned the finished job
- done_wraps  out  CNT_W  wrap pulses seen during the job

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: if exactly one reqN_valid, grant it; if both, grant the one not granted last (last_grant reset = 1, so requester 0 wins first tie). reqN_ready is combinational, high only in IDLE for the granted requester.
- On accept: latch id, dir, steps into remaining; clear wrap count. steps != 0 -> RUN; steps == 0 -> DONE (no step issued).
- RUN: step_en = 1, step_dir = latched dir every cycle. If wrap_in, wraps += 1. remaining -= 1; when remaining == 1 at that edge -> DONE.
- DONE: done_valid = 1, done_id/done_wraps hold the job result; update last_grant = id; -> IDLE. No backpressure on done.
- Wrap count cannot overflow: wraps <= steps <= 2^CNT_W-1.
- reqN_valid/dir/steps are sampled only at the accept edge; changes afterward are ignored. Requests arriving during RUN/DONE wait (ready low).

## Timing
- Reset values: req0_ready = req1_ready = 0 while reset high, step_en 0, step_dir 0, busy 0, done_valid 0, done_id 0, done_wraps 0.
- Accept at edge E (valid & ready high in the cycle before E). step_en high for exactly steps cycles, starting the cycle after E. done_valid high the cycle after the last step_en cycle.
- Job latency accept-to-done: steps+1 cycles; steps == 0 gives 1 cycle. Next accept earliest the cycle after done_valid (done cycle is not IDLE).
- step_en, step_dir, done_* are registered-state decodes (no combinational path from req inputs); only reqN_ready depends combinationally on reqN_valid.
- Reset mid-RUN: step_en drops asynchronously, job discarded, no done pulse; last_grant returns to 1.

## Configuration
- STEP_ARB_ABORT_EN defined: adds input abort (1 bit). abort high in RUN -> step_en low that cycle, DONE next edge, done_wraps = wraps counted before the abort cycle; abort ignored in IDLE/DONE.
- Not defined: no abort port; every job runs to its full step count.

## Test plan
- Reset, req0 steps=5 dir=1 -> req0_ready 1 cycle, step_en high 5 cycles with step_dir 1, done_valid next cycle, done_id 0, done_wraps = count of wrap_in pulses (model counter from S0: 2).
- req0 and req1 valid in the same cycle after reset -> req0 granted; after its done, req1 granted next IDLE cycle; repeat tie -> req0 again.
- req1 steps=0 -> accept, done_valid 1 cycle later, done_wraps 0, step_en never high.
- req0 steps=15 dir=0 from S0 -> 15 step cycles, done_wraps = 4 (wrap on each S3 step with A=0).
- Assert reset in 3rd RUN cycle -> step_en, busy 0 immediately, no done_valid; next job starts cleanly and req0 wins tie.
- With STEP_ARB_ABORT_EN: steps=10, abort in 4th RUN cycle -> 3 step_en cycles, done_valid next cycle with wraps counted over those 3.
